// File: rtl/steering_pkg.sv
`default_nettype none
// ============================================================================
// Module   : steering_pkg
// Purpose  : Shared types, widths and helpers for the steering controller:
//            FSM state encoding, duty-update actions and duty clamping.
// Revision : 1.0 - initial release
// ============================================================================
package steering_pkg;

    // Controller state, encoding visible on the state port
    typedef enum logic [1:0] {
        STOP   = 2'd0,
        TRACK  = 2'd1,
        SEARCH = 2'd2
    } steer_state_t;

    // Duty-register action decided in the first pipeline stage
    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_TRACK  = 2'd1,
        ACT_SEARCH = 2'd2,
        ACT_STOP   = 2'd3
    } duty_act_t;

    // Arithmetic widths of the steering law
    localparam int c_ERR_W  = 12;
    localparam int c_PROD_W = 16;
    localparam int c_SUM_W  = 17;

    // Largest duty a PWM_W-bit counter can express (2^PWM_W - 1)
    function automatic int unsigned duty_max(input int unsigned pwm_w);
        return (32'd1 << pwm_w) - 32'd1;
    endfunction

    // Saturate a signed wheel command into [0, 2^pwm_w - 1]
    function automatic logic [15:0] clamp_duty(input logic signed [16:0] value,
                                               input int unsigned       pwm_w);
        logic signed [16:0] max_v;
        max_v = 17'(duty_max(pwm_w));
        if (value < 0) begin
            return '0;
        end else if (value > max_v) begin
            return max_v[15:0];
        end else begin
            return value[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/steering_controller_pwm.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen
// Purpose  : Free-running PWM counter driving two channels. Each channel keeps
//            a shadow copy of its duty that only reloads at the counter wrap,
//            so a period is never truncated. Outputs are registered so they
//            are glitch-free.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gen
    import steering_pkg::*;
#(
    parameter int PWM_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty_left,
    input  logic [PWM_W-1:0] duty_right,
    output logic             pwm_left,
    output logic             pwm_right
);

    localparam logic [PWM_W-1:0] c_CNT_MAX = '1;

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] w_cnt_next;
    logic             w_wrap;
    logic [PWM_W-1:0] w_duty [2];
    logic [1:0]       w_pwm;

    assign w_cnt_next = r_cnt + 1'b1;
    assign w_wrap     = (r_cnt == c_CNT_MAX);
    assign w_duty[0]  = duty_left;
    assign w_duty[1]  = duty_right;

    // Period counter, restarts at zero on reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [PWM_W-1:0] r_active;
            logic [PWM_W-1:0] w_active_next;
            logic             r_pwm;

            assign w_active_next = w_wrap ? w_duty[gi] : r_active;

            // Shadow duty loads at the wrap; the output register holds
            // (cnt < active_duty) for the cycle the counter is about to enter
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_active <= '0;
                    r_pwm    <= 1'b0;
                end else begin
                    r_active <= w_active_next;
                    r_pwm    <= (w_cnt_next < w_active_next);
                end
            end

            assign w_pwm[gi] = r_pwm;
        end
    endgenerate

    assign pwm_left  = w_pwm[0];
    assign pwm_right = w_pwm[1];

endmodule
`default_nettype wire

// File: rtl/steering_controller.sv
`default_nettype none
// ============================================================================
// Module   : steering_controller
// Purpose  : Turns the per-frame line centroid into left/right motor duties
//            through a proportional steering law, a lost-line search/stop
//            state machine and a dual-channel PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
module steering_controller
    import steering_pkg::*;
#(
    parameter int IMG_W        = 640,
    parameter int PWM_W        = 10,
    parameter int BASE_SPEED   = 512,
    parameter int KP           = 3,
    parameter int KP_SHIFT     = 2,
    parameter int SEARCH_SPEED = 300,
    parameter int LOST_FRAMES  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [10:0]      centroid_x,
    input  logic             centroid_ready,
    input  logic             line_valid,
    input  logic             line_lost,
    output logic             pwm_left,
    output logic             pwm_right,
    output logic [PWM_W-1:0] duty_left,
    output logic [PWM_W-1:0] duty_right,
    output logic [1:0]       state
);

    localparam logic [11:0]                 c_IMG_W  = 12'(IMG_W);
    localparam logic signed [c_ERR_W-1:0]   c_HALF   = 12'(IMG_W / 2);
    localparam logic signed [c_PROD_W-1:0]  c_KP     = 16'(KP);
    localparam logic signed [c_SUM_W-1:0]   c_BASE   = 17'(BASE_SPEED);
    localparam logic [PWM_W-1:0]            c_SEARCH = PWM_W'(SEARCH_SPEED);
    localparam logic [7:0]                  c_LOST   = 8'(LOST_FRAMES);

    // ------------------------------------------------------------------
    // Frame qualification and first-stage arithmetic
    // ------------------------------------------------------------------
    logic                        w_valid;
    logic signed [c_ERR_W-1:0]   w_err;
    logic signed [c_PROD_W-1:0]  w_err_ext;
    logic signed [c_PROD_W-1:0]  w_prod;

    // line_lost overrides line_valid; columns outside the image are rejected
    assign w_valid   = line_valid & ~line_lost & ({1'b0, centroid_x} < c_IMG_W);
    assign w_err     = $signed({1'b0, centroid_x}) - c_HALF;
    assign w_err_ext = {{(c_PROD_W - c_ERR_W){w_err[c_ERR_W-1]}}, w_err};
    assign w_prod    = w_err_ext * c_KP;

    // ------------------------------------------------------------------
    // FSM and stage-1 registers
    // ------------------------------------------------------------------
    steer_state_t                r_state;
    steer_state_t                w_state_next;
    duty_act_t                   w_act;
    duty_act_t                   r_act;
    logic [7:0]                  r_lost_cnt;
    logic [7:0]                  w_lost_next;
    logic [7:0]                  w_lost_inc;
    logic                        w_lost_hit;
    logic signed [c_ERR_W-1:0]   r_last_err;
    logic signed [c_PROD_W-1:0]  r_prod;
    logic                        r_search_right;

    assign w_lost_inc = r_lost_cnt + 8'd1;
    assign w_lost_hit = (w_lost_inc == c_LOST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision; enable low forces STOP regardless of any frame
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = STOP;
        end else if (centroid_ready) begin
            case (r_state)
                STOP: begin
                    if (w_valid) w_state_next = TRACK;
                end
                TRACK: begin
                    if (w_valid)                 w_state_next = TRACK;
                    else if (c_LOST == 8'd1)     w_state_next = STOP;
                    else                         w_state_next = SEARCH;
                end
                SEARCH: begin
                    if (w_valid)                 w_state_next = TRACK;
                    else if (w_lost_hit)         w_state_next = STOP;
                end
                default: w_state_next = STOP;
            endcase
        end
    end

    // Per-frame outputs of the FSM: duty action and lost-frame counter
    always_comb begin
        w_act       = ACT_NONE;
        w_lost_next = r_lost_cnt;
        if (!enable) begin
            w_act       = ACT_STOP;
            w_lost_next = '0;
        end else if (centroid_ready) begin
            case (r_state)
                STOP: begin
                    if (w_valid) w_act = ACT_TRACK;
                    w_lost_next = '0;
                end
                TRACK: begin
                    if (w_valid) begin
                        w_act       = ACT_TRACK;
                        w_lost_next = '0;
                    end else if (c_LOST == 8'd1) begin
                        w_act       = ACT_STOP;
                        w_lost_next = '0;
                    end else begin
                        w_act       = ACT_SEARCH;
                        w_lost_next = 8'd1;
                    end
                end
                SEARCH: begin
                    if (w_valid) begin
                        w_act       = ACT_TRACK;
                        w_lost_next = '0;
                    end else if (w_lost_hit) begin
                        w_act       = ACT_STOP;
                        w_lost_next = '0;
                    end else begin
                        w_lost_next = w_lost_inc;
                    end
                end
                default: begin
                    w_act       = ACT_STOP;
                    w_lost_next = '0;
                end
            endcase
        end
    end

    // Stage-1 pipeline: register the action, the product and the error memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act          <= ACT_NONE;
            r_lost_cnt     <= '0;
            r_last_err     <= '0;
            r_prod         <= '0;
            r_search_right <= 1'b0;
        end else begin
            r_act      <= w_act;
            r_lost_cnt <= w_lost_next;
            if (enable && centroid_ready && w_valid) begin
                r_last_err <= w_err;
                r_prod     <= w_prod;
            end
            // Search toward the side the line was last seen on
            if (w_act == ACT_SEARCH) begin
                r_search_right <= (r_last_err < 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage-2: correction, wheel sums and duty registers
    // ------------------------------------------------------------------
    logic signed [c_SUM_W-1:0] w_corr;
    logic signed [c_SUM_W-1:0] w_sum_left;
    logic signed [c_SUM_W-1:0] w_sum_right;

    assign w_corr      = $signed({r_prod[c_PROD_W-1], r_prod}) >>> KP_SHIFT;
    assign w_sum_left  = c_BASE + w_corr;
    assign w_sum_right = c_BASE - w_corr;

    // Duty registers; enable low zeroes them on the very next clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_left  <= '0;
            duty_right <= '0;
        end else if (!enable) begin
            duty_left  <= '0;
            duty_right <= '0;
        end else begin
            case (r_act)
                ACT_TRACK: begin
                    duty_left  <= PWM_W'(clamp_duty(w_sum_left, PWM_W));
                    duty_right <= PWM_W'(clamp_duty(w_sum_right, PWM_W));
                end
                ACT_SEARCH: begin
                    if (r_search_right) begin
                        duty_left  <= '0;
                        duty_right <= c_SEARCH;
                    end else begin
                        duty_left  <= c_SEARCH;
                        duty_right <= '0;
                    end
                end
                ACT_STOP: begin
                    duty_left  <= '0;
                    duty_right <= '0;
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

    // ------------------------------------------------------------------
    // PWM generator
    // ------------------------------------------------------------------
    pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty_left  (duty_left),
        .duty_right (duty_right),
        .pwm_left   (pwm_left),
        .pwm_right  (pwm_right)
    );

endmodule
`default_nettype wire

// File: tb/tb_steering_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_steering_controller
// Purpose  : Directed self-checking bench for steering_controller. A default
//            instance and a high-gain instance (KP=8, KP_SHIFT=0,
//            LOST_FRAMES=1) share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_steering_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        centroid_ready = 1'b0;
    logic        line_valid = 1'b0;
    logic        line_lost = 1'b0;
    logic [10:0] centroid_x = '0;

    logic        pwm_left, pwm_right;
    logic [9:0]  duty_left, duty_right;
    logic [1:0]  state;

    logic        pwm_left_c, pwm_right_c;
    logic [9:0]  duty_left_c, duty_right_c;
    logic [1:0]  state_c;

    int n_checks = 0;
    int n_fail   = 0;
    int hl, hr;

    always #5 clk = ~clk;

    steering_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .centroid_x     (centroid_x),
        .centroid_ready (centroid_ready),
        .line_valid     (line_valid),
        .line_lost      (line_lost),
        .pwm_left       (pwm_left),
        .pwm_right      (pwm_right),
        .duty_left      (duty_left),
        .duty_right     (duty_right),
        .state          (state)
    );

    steering_controller #(
        .KP          (8),
        .KP_SHIFT    (0),
        .LOST_FRAMES (1)
    ) dut_c (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .centroid_x     (centroid_x),
        .centroid_ready (centroid_ready),
        .line_valid     (line_valid),
        .line_lost      (line_lost),
        .pwm_left       (pwm_left_c),
        .pwm_right      (pwm_right_c),
        .duty_left      (duty_left_c),
        .duty_right     (duty_right_c),
        .state          (state_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle centroid_ready pulse; returns just after the sampling edge
    task automatic frame(input int x, input logic v, input logic l);
        @(negedge clk);
        centroid_x     = 11'(x);
        line_valid     = v;
        line_lost      = l;
        centroid_ready = 1'b1;
        @(negedge clk);
        centroid_ready = 1'b0;
        line_valid     = 1'b0;
        line_lost      = 1'b0;
    endtask

    // Frame followed by one more cycle so duties have settled
    task automatic frame_settled(input int x, input logic v, input logic l);
        frame(x, v, l);
        @(negedge clk);
    endtask

    // Wait for a low-to-high transition of pwm_left (bounded)
    task automatic wait_pwm_rise(input string tag);
        int i;
        i = 0;
        while (pwm_left !== 1'b0 && i < 2100) begin @(negedge clk); i++; end
        while (pwm_left !== 1'b1 && i < 4200) begin @(negedge clk); i++; end
        check(tag, 32'(pwm_left), 32'd1);
    endtask

    task automatic measure(input int n, output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_left)  cl++;
            if (pwm_right) cr++;
            @(negedge clk);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_state",    32'(state),      32'd0);
        check("rst_duty_l",   32'(duty_left),  32'd0);
        check("rst_duty_r",   32'(duty_right), 32'd0);
        check("rst_pwm_l",    32'(pwm_left),   32'd0);
        check("rst_pwm_c",    32'(pwm_left_c), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // ---------------- track right ----------------
        frame(400, 1'b1, 1'b0);
        check("tr_state_n1",  32'(state),      32'd1);
        check("tr_duty_n1",   32'(duty_left),  32'd0);
        @(negedge clk);
        check("tr_duty_l",    32'(duty_left),  32'd572);
        check("tr_duty_r",    32'(duty_right), 32'd452);
        check("tr_c_duty_l",  32'(duty_left_c),  32'd1023);
        check("tr_c_duty_r",  32'(duty_right_c), 32'd0);
        wait_pwm_rise("tr_pwm_rise");
        measure(1024, hl, hr);
        check("tr_high_l",    32'(hl), 32'd572);
        check("tr_high_r",    32'(hr), 32'd452);

        // ---------------- track far left ----------------
        frame_settled(0, 1'b1, 1'b0);
        check("fl_duty_l",    32'(duty_left),    32'd272);
        check("fl_duty_r",    32'(duty_right),   32'd752);
        check("fl_c_duty_l",  32'(duty_left_c),  32'd0);
        check("fl_c_duty_r",  32'(duty_right_c), 32'd1023);

        // ---------------- right edge / clamp ----------------
        frame_settled(639, 1'b1, 1'b0);
        check("re_duty_l",    32'(duty_left),    32'd751);
        check("re_duty_r",    32'(duty_right),   32'd273);
        check("cl_duty_l",    32'(duty_left_c),  32'd1023);
        check("cl_duty_r",    32'(duty_right_c), 32'd0);

        // ---------------- lost line ----------------
        frame_settled(400, 1'b1, 1'b0);
        check("pre_lost_l",   32'(duty_left),  32'd572);
        // frame 1: valid and lost both high -> invalid
        frame(400, 1'b1, 1'b1);
        check("lost1_state",  32'(state),   32'd2);
        check("lf1_c_state",  32'(state_c), 32'd0);
        @(negedge clk);
        check("lost1_duty_l", 32'(duty_left),    32'd300);
        check("lost1_duty_r", 32'(duty_right),   32'd0);
        check("lf1_c_duty_l", 32'(duty_left_c),  32'd0);
        // frame 2: out-of-range column -> invalid
        frame_settled(700, 1'b1, 1'b0);
        check("range_state",  32'(state),   32'd2);
        check("range_c_state", 32'(state_c), 32'd0);
        // frames 3..14
        for (int i = 3; i <= 14; i++) begin
            frame_settled(i * 37, 1'b0, 1'b0);
        end
        check("lost14_state", 32'(state),     32'd2);
        check("lost14_duty",  32'(duty_left), 32'd300);
        // frame 15 -> STOP
        frame(200, 1'b0, 1'b1);
        check("lost15_state", 32'(state),     32'd0);
        check("lost15_n1",    32'(duty_left), 32'd300);
        @(negedge clk);
        check("lost15_dl",    32'(duty_left),  32'd0);
        check("lost15_dr",    32'(duty_right), 32'd0);

        // ---------------- recovery clears lost count ----------------
        frame_settled(400, 1'b1, 1'b0);
        check("rec_state",    32'(state), 32'd1);
        for (int i = 0; i < 5; i++) begin
            frame_settled(100, 1'b0, 1'b0);
        end
        check("rec_srch",     32'(state), 32'd2);
        frame_settled(0, 1'b1, 1'b0);
        check("rec_track",    32'(state),      32'd1);
        check("rec_duty_r",   32'(duty_right), 32'd752);
        frame_settled(50, 1'b0, 1'b0);
        check("mir_duty_l",   32'(duty_left),  32'd0);
        check("mir_duty_r",   32'(duty_right), 32'd300);
        for (int i = 2; i <= 14; i++) begin
            frame_settled(50, 1'b0, 1'b0);
        end
        check("rec14_state",  32'(state), 32'd2);
        frame_settled(50, 1'b0, 1'b0);
        check("rec15_state",  32'(state), 32'd0);

        // ---------------- enable drop mid-period ----------------
        frame_settled(400, 1'b1, 1'b0);
        check("en_track",     32'(state), 32'd1);
        wait_pwm_rise("en_pwm_rise");
        for (int i = 0; i < 100; i++) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("en_state",     32'(state),      32'd0);
        check("en_duty_l",    32'(duty_left),  32'd0);
        check("en_duty_r",    32'(duty_right), 32'd0);
        check("en_pwm_held",  32'(pwm_left),   32'd1);
        measure(2100, hl, hr);
        check("en_tail_l",    32'(hl), 32'd471);
        check("en_tail_r",    32'(hr), 32'd351);

        // ---------------- asynchronous reset mid-period ----------------
        enable = 1'b1;
        frame_settled(400, 1'b1, 1'b0);
        wait_pwm_rise("ar_pwm_rise");
        for (int i = 0; i < 50; i++) @(negedge clk);
        check("ar_pwm_pre",   32'(pwm_left), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pwm_l",     32'(pwm_left),   32'd0);
        check("ar_pwm_r",     32'(pwm_right),  32'd0);
        check("ar_duty_l",    32'(duty_left),  32'd0);
        check("ar_state",     32'(state),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
